// File: rtl/htif_mem_arbiter_if.sv
// Bundled request/response channels between the 4 HTIF requesters, the arbiter and memory.
// The master modport is the arbiter's view; the slave modport is the requesters plus memory.
interface htif_mem_arbiter_if #(
   parameter int TAG_BITS  = 4,
   parameter int ADDR_BITS = 14,
   parameter int DATA_BITS = 128
);
   logic [3:0]             req_val;
   logic [3:0]             req_rdy;
   logic [3:0]             req_rw;
   logic [4*ADDR_BITS-1:0] req_addr;
   logic [4*DATA_BITS-1:0] req_data;
   logic [4*TAG_BITS-1:0]  req_tag;
   logic [3:0]             resp_val;
   logic [DATA_BITS-1:0]   resp_data;
   logic [TAG_BITS-1:0]    resp_tag;
   logic                   mem_req_val;
   logic                   mem_req_rdy;
   logic                   mem_req_rw;
   logic [ADDR_BITS-1:0]   mem_req_addr;
   logic [DATA_BITS-1:0]   mem_req_data;
   logic [TAG_BITS+1:0]    mem_req_tag;
   logic                   mem_resp_val;
   logic [DATA_BITS-1:0]   mem_resp_data;
   logic [TAG_BITS+1:0]    mem_resp_tag;

   modport master (
      input  req_val, req_rw, req_addr, req_data, req_tag,
      input  mem_req_rdy, mem_resp_val, mem_resp_data, mem_resp_tag,
      output req_rdy, resp_val, resp_data, resp_tag,
      output mem_req_val, mem_req_rw, mem_req_addr, mem_req_data, mem_req_tag
   );

   modport slave (
      output req_val, req_rw, req_addr, req_data, req_tag,
      output mem_req_rdy, mem_resp_val, mem_resp_data, mem_resp_tag,
      input  req_rdy, resp_val, resp_data, resp_tag,
      input  mem_req_val, mem_req_rw, mem_req_addr, mem_req_data, mem_req_tag
   );
endinterface

// File: rtl/htif_mem_arbiter.sv
// Round-robin arbiter sharing one HTIF memory channel among 4 requesters, with a
// one-entry registered output stage, ID-routed responses and an in-flight read limit.
module htif_mem_arbiter #(
   parameter int TAG_BITS        = 4,
   parameter int ADDR_BITS       = 14,
   parameter int DATA_BITS       = 128,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                clk,
   input  logic                reset,
   htif_mem_arbiter_if.master  bus,
   output logic [3:0]          outstanding,
   output logic                err
);

   logic                 mem_req_val_q;
   logic                 mem_req_rw_q;
   logic [ADDR_BITS-1:0] mem_req_addr_q;
   logic [DATA_BITS-1:0] mem_req_data_q;
   logic [TAG_BITS+1:0]  mem_req_tag_q;
   logic [3:0]           outstanding_q;
   logic                 err_q;
   logic [1:0]           ptr;

   logic                 stage_free;
   logic                 pending_read;
   logic                 read_ok;
   logic [3:0]           eligible;
   logic                 gnt_any;
   logic [1:0]           gnt_id;
   logic [3:0]           req_rdy_c;
   logic                 rd_issue;

   assign stage_free   = !mem_req_val_q || bus.mem_req_rdy;
   // A read draining this cycle still counts: it lands in outstanding next cycle.
   assign pending_read = mem_req_val_q && !mem_req_rw_q;
   assign read_ok      = ({1'b0, outstanding_q} + {4'b0000, pending_read}) < 5'(MAX_OUTSTANDING);
   assign eligible     = bus.req_val & (bus.req_rw | {4{read_ok}});
   assign rd_issue     = mem_req_val_q && bus.mem_req_rdy && !mem_req_rw_q;

   always_comb begin
      gnt_any   = 1'b0;
      gnt_id    = ptr;
      req_rdy_c = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         if (!gnt_any && eligible[ptr + 2'(k)]) begin
            gnt_any = 1'b1;
            gnt_id  = ptr + 2'(k);
         end
      end
      if (stage_free && gnt_any) req_rdy_c[gnt_id] = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_req_val_q  <= 1'b0;
         mem_req_rw_q   <= 1'b0;
         mem_req_addr_q <= '0;
         mem_req_data_q <= '0;
         mem_req_tag_q  <= '0;
         outstanding_q  <= 4'd0;
         err_q          <= 1'b0;
         ptr            <= 2'd0;
      end else begin
         if (stage_free) begin
            mem_req_val_q <= gnt_any;
            if (gnt_any) begin
               mem_req_rw_q   <= bus.req_rw[gnt_id];
               mem_req_addr_q <= bus.req_addr[gnt_id*ADDR_BITS +: ADDR_BITS];
               mem_req_data_q <= bus.req_data[gnt_id*DATA_BITS +: DATA_BITS];
               mem_req_tag_q  <= {gnt_id, bus.req_tag[gnt_id*TAG_BITS +: TAG_BITS]};
               ptr            <= gnt_id + 2'd1;
            end
         end
         if (rd_issue && !bus.mem_resp_val) begin
            outstanding_q <= outstanding_q + 4'd1;
         end else if (bus.mem_resp_val && !rd_issue) begin
            if (outstanding_q == 4'd0) err_q <= 1'b1;
            else                       outstanding_q <= outstanding_q - 4'd1;
         end
      end
   end

   assign bus.req_rdy      = req_rdy_c;
   assign bus.mem_req_val  = mem_req_val_q;
   assign bus.mem_req_rw   = mem_req_rw_q;
   assign bus.mem_req_addr = mem_req_addr_q;
   assign bus.mem_req_data = mem_req_data_q;
   assign bus.mem_req_tag  = mem_req_tag_q;
   assign outstanding      = outstanding_q;
   assign err              = err_q;

   // Responses are never backpressured, so routing is purely combinational.
   assign bus.resp_val  = bus.mem_resp_val ? (4'b0001 << bus.mem_resp_tag[TAG_BITS+1:TAG_BITS]) : 4'b0000;
   assign bus.resp_data = bus.mem_resp_data;
   assign bus.resp_tag  = bus.mem_resp_tag[TAG_BITS-1:0];

endmodule

// File: tb/tb_htif_mem_arbiter.sv
// Bench for htif_mem_arbiter: directed scenarios plus a grant-to-memory payload scoreboard.
module tb_htif_mem_arbiter;
   localparam int TB = 4;
   localparam int AW = 14;
   localparam int DW = 128;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] outstanding;
   logic       err;

   htif_mem_arbiter_if #(.TAG_BITS(TB), .ADDR_BITS(AW), .DATA_BITS(DW)) bus ();

   htif_mem_arbiter #(.TAG_BITS(TB), .ADDR_BITS(AW), .DATA_BITS(DW), .MAX_OUTSTANDING(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus.master),
      .outstanding (outstanding),
      .err         (err)
   );

   always #5 clk = ~clk;

   int           n_chk = 0;
   int           n_err = 0;
   logic [159:0] exp_q[$];
   int           gnt_log[$];
   int           rr_exp[5] = '{0, 1, 2, 3, 0};

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [159:0] pk(input logic rw, input logic [AW-1:0] a,
                                       input logic [DW-1:0] d, input logic [TB+1:0] t);
      return {11'b0, rw, a, d, t};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic rw, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [TB-1:0] t);
      bus.req_rw[i]           = rw;
      bus.req_addr[i*AW +: AW] = a;
      bus.req_data[i*DW +: DW] = d;
      bus.req_tag[i*TB +: TB]  = t;
   endtask

   task automatic do_reset();
      reset            = 1'b1;
      bus.req_val      = 4'b0000;
      bus.mem_resp_val = 1'b0;
      bus.mem_req_rdy  = 1'b0;
      #2;
      exp_q.delete();
      @(negedge clk);
      reset = 1'b0;
      step();
   endtask

   // Scoreboard: grants push the expected downstream beat; downstream handshakes pop it.
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.mem_req_val && bus.mem_req_rdy) begin
            if (exp_q.size() == 0) chk("sb_underflow", 160'(exp_q.size()), 160'd1);
            else chk("sb_payload", pk(bus.mem_req_rw, bus.mem_req_addr, bus.mem_req_data, bus.mem_req_tag),
                     exp_q.pop_front());
         end
         chk("rdy_onehot0", 160'($onehot0(bus.req_rdy)), 160'd1);
         for (int i = 0; i < 4; i++) begin
            if (bus.req_val[i] && bus.req_rdy[i]) begin
               exp_q.push_back(pk(bus.req_rw[i], bus.req_addr[i*AW +: AW], bus.req_data[i*DW +: DW],
                                  {2'(i), bus.req_tag[i*TB +: TB]}));
               gnt_log.push_back(i);
            end
         end
         if (bus.mem_resp_val) begin
            chk("resp_route", 160'(bus.resp_val), 160'(4'b0001 << bus.mem_resp_tag[TB+1:TB]));
            chk("resp_data", 160'(bus.resp_data), 160'(bus.mem_resp_data));
            chk("resp_tag", 160'(bus.resp_tag), 160'(bus.mem_resp_tag[TB-1:0]));
         end
      end
   end

   initial begin
      reset = 1'b1;
      bus.req_val = '0; bus.req_rw = '0; bus.req_addr = '0; bus.req_data = '0; bus.req_tag = '0;
      bus.mem_req_rdy = 1'b0; bus.mem_resp_val = 1'b0; bus.mem_resp_data = '0; bus.mem_resp_tag = '0;
      #1;
      chk("rst_val", 160'(bus.mem_req_val), 160'd0);
      chk("rst_addr", 160'(bus.mem_req_addr), 160'd0);
      chk("rst_tag", 160'(bus.mem_req_tag), 160'd0);
      chk("rst_out", 160'(outstanding), 160'd0);
      chk("rst_err", 160'(err), 160'd0);
      @(negedge clk);
      reset = 1'b0;
      step();

      // single read
      set_req(0, 1'b0, 14'h0040, 128'hA0, 4'd3);
      bus.req_val = 4'b0001;
      @(negedge clk);
      chk("t1_rdy", 160'(bus.req_rdy), 160'b0001);
      step();
      bus.req_val = 4'b0000;
      chk("t1_val", 160'(bus.mem_req_val), 160'd1);
      chk("t1_addr", 160'(bus.mem_req_addr), 160'h0040);
      chk("t1_tag", 160'(bus.mem_req_tag), 160'b000011);
      chk("t1_out_pre", 160'(outstanding), 160'd0);
      bus.mem_req_rdy = 1'b1;
      step();
      chk("t1_drain", 160'(bus.mem_req_val), 160'd0);
      chk("t1_out1", 160'(outstanding), 160'd1);
      bus.mem_resp_val = 1'b1; bus.mem_resp_tag = 6'b000011; bus.mem_resp_data = 128'hDEAD_BEEF;
      @(negedge clk);
      chk("t1_resp_val", 160'(bus.resp_val), 160'b0001);
      chk("t1_resp_tag", 160'(bus.resp_tag), 160'd3);
      step();
      bus.mem_resp_val = 1'b0;
      chk("t1_out0", 160'(outstanding), 160'd0);

      // round-robin fairness with writes
      do_reset();
      bus.mem_req_rdy = 1'b1;
      for (int i = 0; i < 4; i++) set_req(i, 1'b1, 14'(14'h100 + i), 128'(32'h1000 + i), 4'(i + 5));
      gnt_log.delete();
      bus.req_val = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("rr_val", 160'(bus.mem_req_val), 160'd1);
      end
      bus.req_val = 4'b0000;
      chk("rr_count", 160'(gnt_log.size()), 160'd5);
      for (int k = 0; k < 5; k++)
         if (k < gnt_log.size()) chk("rr_order", 160'(gnt_log[k]), 160'(rr_exp[k]));

      // backpressure: requester 0's write is held in the stage
      bus.mem_req_rdy = 1'b0;
      bus.req_val = 4'b0011;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_rdy", 160'(bus.req_rdy), 160'd0);
         step();
         chk("bp_val", 160'(bus.mem_req_val), 160'd1);
         chk("bp_addr", 160'(bus.mem_req_addr), 160'h100);
         chk("bp_tag", 160'(bus.mem_req_tag), 160'h05);
      end
      bus.mem_req_rdy = 1'b1;
      @(negedge clk);
      chk("bp_grant", 160'(bus.req_rdy), 160'b0010);
      step();
      bus.req_val = 4'b0000;
      chk("bp_addr2", 160'(bus.mem_req_addr), 160'h101);
      chk("bp_tag2", 160'(bus.mem_req_tag), 160'h16);
      step();
      step();
      chk("bp_idle", 160'(bus.mem_req_val), 160'd0);

      // read limit
      do_reset();
      bus.mem_req_rdy = 1'b1;
      gnt_log.delete();
      set_req(2, 1'b0, 14'h200, 128'h0, 4'd7);
      set_req(3, 1'b1, 14'h300, 128'hBEEF, 4'd8);
      bus.req_val = 4'b0100;
      repeat (12) step();
      chk("lim_out", 160'(outstanding), 160'd8);
      chk("lim_grants", 160'(gnt_log.size()), 160'd8);
      @(negedge clk);
      chk("lim_stall", 160'(bus.req_rdy), 160'd0);
      step();
      bus.req_val = 4'b1100;
      @(negedge clk);
      chk("lim_wr_rdy", 160'(bus.req_rdy), 160'b1000);
      step();
      bus.req_val = 4'b0100;
      chk("lim_wr_addr", 160'(bus.mem_req_addr), 160'h300);
      chk("lim_wr_rw", 160'(bus.mem_req_rw), 160'd1);
      bus.mem_resp_val = 1'b1; bus.mem_resp_tag = {2'd2, 4'd7}; bus.mem_resp_data = 128'h77;
      @(negedge clk);
      chk("lim_resp", 160'(bus.resp_val), 160'b0100);
      step();
      bus.mem_resp_val = 1'b0;
      chk("lim_out7", 160'(outstanding), 160'd7);
      @(negedge clk);
      chk("lim_reissue", 160'(bus.req_rdy), 160'b0100);
      step();
      bus.req_val = 4'b0000;
      chk("lim_rd_addr", 160'(bus.mem_req_addr), 160'h200);
      step();
      chk("lim_out8", 160'(outstanding), 160'd8);
      bus.mem_resp_val = 1'b1; bus.mem_resp_tag = {2'd2, 4'd7};
      repeat (3) step();
      bus.mem_resp_val = 1'b0;
      chk("lim_out5", 160'(outstanding), 160'd5);

      // simultaneous issue and response at outstanding = 5
      bus.mem_req_rdy = 1'b0;
      set_req(0, 1'b0, 14'h050, 128'h0, 4'd1);
      bus.req_val = 4'b0001;
      @(negedge clk);
      chk("sim_rdy", 160'(bus.req_rdy), 160'b0001);
      step();
      bus.req_val = 4'b0000;
      bus.mem_req_rdy = 1'b1;
      bus.mem_resp_val = 1'b1; bus.mem_resp_tag = {2'd2, 4'd9}; bus.mem_resp_data = 128'h99;
      @(negedge clk);
      chk("sim_resp_val", 160'(bus.resp_val), 160'b0100);
      chk("sim_resp_tag", 160'(bus.resp_tag), 160'd9);
      step();
      bus.mem_resp_val = 1'b0;
      chk("sim_out5", 160'(outstanding), 160'd5);
      chk("sim_drained", 160'(bus.mem_req_val), 160'd0);
      bus.mem_resp_val = 1'b1; bus.mem_resp_tag = {2'd0, 4'd1};
      repeat (5) step();
      bus.mem_resp_val = 1'b0;
      chk("drain_out0", 160'(outstanding), 160'd0);
      chk("drain_err0", 160'(err), 160'd0);

      // spurious response
      bus.mem_resp_val = 1'b1; bus.mem_resp_tag = {2'd1, 4'd2};
      @(negedge clk);
      chk("sp_route", 160'(bus.resp_val), 160'b0010);
      step();
      bus.mem_resp_val = 1'b0;
      chk("sp_err", 160'(err), 160'd1);
      chk("sp_out", 160'(outstanding), 160'd0);
      repeat (3) step();
      chk("sp_err_hold", 160'(err), 160'd1);

      // asynchronous reset while stalled
      bus.mem_req_rdy = 1'b0;
      set_req(1, 1'b1, 14'h111, 128'h11, 4'd4);
      bus.req_val = 4'b0010;
      step();
      bus.req_val = 4'b0000;
      chk("ar_val", 160'(bus.mem_req_val), 160'd1);
      #2;
      reset = 1'b1;
      exp_q.delete();
      #1;
      chk("ar_drop", 160'(bus.mem_req_val), 160'd0);
      chk("ar_err", 160'(err), 160'd0);
      chk("ar_out", 160'(outstanding), 160'd0);
      @(negedge clk);
      reset = 1'b0;
      step();
      bus.mem_resp_val = 1'b1; bus.mem_resp_tag = {2'd0, 4'd3};
      step();
      bus.mem_resp_val = 1'b0;
      chk("late_resp_err", 160'(err), 160'd1);

      do_reset();
      chk("sb_empty", 160'(exp_q.size()), 160'd0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
